// File: rtl/cam_pkg.sv
// Shared sizing constants and types for the CAM core and its priority encoder.
package cam_pkg;

   localparam int CAM_WIDTH_LOG2 = 5;
   localparam int CAM_SIZE_LOG2  = 5;
   localparam int W              = 2 ** CAM_WIDTH_LOG2;
   localparam int AS             = CAM_SIZE_LOG2;
   localparam int DEPTH          = 2 ** CAM_SIZE_LOG2;

   typedef logic [W-1:0]     cam_data_t;
   typedef logic [AS-1:0]    cam_idx_t;
   typedef logic [DEPTH-1:0] cam_vec_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module cam_prio_enc #(
   parameter int AS = 5
) (
   input  logic [2**AS-1:0] vec,
   output logic [AS-1:0]    idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = |vec;
      // Walking downwards lets the lowest set bit overwrite any higher one.
      for (int i = 2**AS - 1; i >= 0; i--) begin
         if (vec[i]) idx = i[AS-1:0];
      end
   end

endmodule

// File: rtl/cam_core.sv
// Flop-based CAM responder: read, write and search, all results registered with 1-cycle latency.
module cam_core
   import cam_pkg::*;
#(
   parameter int ARRAY_WIDTH_LOG2 = CAM_WIDTH_LOG2,
   parameter int ARRAY_SIZE_LOG2  = CAM_SIZE_LOG2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             read_i,
   input  logic [ARRAY_SIZE_LOG2-1:0]       read_index_i,
   input  logic                             write_i,
   input  logic [ARRAY_SIZE_LOG2-1:0]       write_index_i,
   input  logic [2**ARRAY_WIDTH_LOG2-1:0]   write_data_i,
   input  logic                             search_i,
   input  logic [2**ARRAY_WIDTH_LOG2-1:0]   search_data_i,
   output logic                             read_valid_o,
   output logic [2**ARRAY_WIDTH_LOG2-1:0]   read_value_o,
   output logic                             search_valid_o,
   output logic [ARRAY_SIZE_LOG2-1:0]       search_index_o
);

   localparam int DW = 2 ** ARRAY_WIDTH_LOG2;
   localparam int ND = 2 ** ARRAY_SIZE_LOG2;

   logic [DW-1:0]              data_q [ND];
   logic [ND-1:0]              valid_q;
   logic [ND-1:0]              match;
   logic [ARRAY_SIZE_LOG2-1:0] match_idx;
   logic                       match_any;
   logic                       read_hit;

   always_comb begin
      match = '0;
      for (int i = 0; i < ND; i++) begin
         match[i] = valid_q[i] && (data_q[i] == search_data_i);
      end
   end

   cam_prio_enc #(
      .AS (ARRAY_SIZE_LOG2)
   ) u_prio_enc (
      .vec (match),
      .idx (match_idx),
      .any (match_any)
   );

   assign read_hit = read_i && valid_q[read_index_i];

   // Data needs no reset; validity alone decides whether an entry can hit.
   always_ff @(posedge clk) begin
      if (!reset && write_i) data_q[write_index_i] <= write_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q        <= '0;
         read_valid_o   <= 1'b0;
         read_value_o   <= '0;
         search_valid_o <= 1'b0;
         search_index_o <= '0;
      end else begin
         if (write_i) valid_q[write_index_i] <= 1'b1;
         // Results come from the pre-write array: no bypass of a same-cycle write.
         read_valid_o   <= read_hit;
         read_value_o   <= read_hit ? data_q[read_index_i] : '0;
         search_valid_o <= search_i && match_any;
         search_index_o <= (search_i && match_any) ? match_idx : '0;
      end
   end

endmodule

// File: tb/tb_cam_core.sv
// Scoreboard bench for cam_core: directed scenarios followed by random traffic against a simple array model.
module tb_cam_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read_i = 1'b0;
   logic [4:0]  read_index_i = '0;
   logic        write_i = 1'b0;
   logic [4:0]  write_index_i = '0;
   logic [31:0] write_data_i = '0;
   logic        search_i = 1'b0;
   logic [31:0] search_data_i = '0;
   logic        read_valid_o;
   logic [31:0] read_value_o;
   logic        search_valid_o;
   logic [4:0]  search_index_o;

   typedef struct {
      logic        rv;
      logic [31:0] rval;
      logic        sv;
      logic [4:0]  sidx;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_data [32];
   bit          m_valid [32];
   int          n_checks = 0;
   int          n_fail = 0;
   string       cur_tag = "init";

   always #5 clk = ~clk;

   cam_core dut (
      .clk            (clk),
      .reset          (reset),
      .read_i         (read_i),
      .read_index_i   (read_index_i),
      .write_i        (write_i),
      .write_index_i  (write_index_i),
      .write_data_i   (write_data_i),
      .search_i       (search_i),
      .search_data_i  (search_data_i),
      .read_valid_o   (read_valid_o),
      .read_value_o   (read_value_o),
      .search_valid_o (search_valid_o),
      .search_index_o (search_index_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are present every cycle, one response per issued cycle.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, ".read_valid"},   {31'd0, read_valid_o},   {31'd0, e.rv});
         check({e.tag, ".read_value"},   read_value_o,            e.rval);
         check({e.tag, ".search_valid"}, {31'd0, search_valid_o}, {31'd0, e.sv});
         check({e.tag, ".search_index"}, {27'd0, search_index_o}, {27'd0, e.sidx});
      end
   end

   // Issue one cycle of stimulus; the expectation is taken from the model before the write lands.
   task automatic drive(input bit rst, input bit rd, input int ridx, input bit wr, input int widx,
                        input logic [31:0] wdat, input bit sr, input logic [31:0] sdat);
      exp_t e;
      @(negedge clk);
      reset         = rst;
      read_i        = rd;
      read_index_i  = ridx[4:0];
      write_i       = wr;
      write_index_i = widx[4:0];
      write_data_i  = wdat;
      search_i      = sr;
      search_data_i = sdat;
      e.rv = 1'b0; e.rval = '0; e.sv = 1'b0; e.sidx = '0; e.tag = cur_tag;
      if (!rst) begin
         if (rd && m_valid[ridx]) begin
            e.rv   = 1'b1;
            e.rval = m_data[ridx];
         end
         if (sr) begin
            for (int i = 0; i < 32; i++) begin
               if (m_valid[i] && m_data[i] == sdat) begin
                  e.sv   = 1'b1;
                  e.sidx = i[4:0];
                  break;
               end
            end
         end
      end
      sb.push_back(e);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      end else if (wr) begin
         m_valid[widx] = 1'b1;
         m_data[widx]  = wdat;
      end
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = '0;
      end

      cur_tag = "t1_reset";
      drive(1, 1, 3, 1, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF);
      cur_tag = "t1_after";
      drive(0, 1, 3, 0, 0, 32'h0, 1, 32'hDEADBEEF);

      cur_tag = "t2";
      drive(0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 32'h0);
      drive(0, 1, 5, 0, 0, 32'h0, 1, 32'hA5A5A5A5);

      cur_tag = "t3";
      drive(0, 0, 0, 1, 9, 32'h1234, 0, 32'h0);
      drive(0, 0, 0, 1, 2, 32'h1234, 0, 32'h0);
      drive(0, 0, 0, 0, 0, 32'h0, 1, 32'h1234);
      drive(0, 0, 0, 1, 2, 32'h0, 0, 32'h0);
      drive(0, 1, 2, 0, 0, 32'h0, 1, 32'h1234);

      cur_tag = "t4";
      drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      drive(0, 1, 7, 1, 7, 32'h77, 1, 32'h77);
      drive(0, 1, 7, 0, 0, 32'h0, 1, 32'h77);

      cur_tag = "t5";
      for (int i = 0; i < 32; i++) drive(0, 0, 0, 1, i, 32'(i + 100), 0, 32'h0);
      for (int i = 0; i < 32; i++) drive(0, 1, i, 0, 0, 32'h0, 1, 32'(i + 100));

      cur_tag = "t6";
      drive(0, 0, 0, 0, 0, 32'h0, 1, 32'd110);
      drive(1, 1, 10, 1, 4, 32'h55, 1, 32'd120);
      drive(0, 1, 10, 0, 0, 32'h0, 1, 32'd110);
      drive(0, 1, 4, 0, 0, 32'h0, 1, 32'h55);

      cur_tag = "random";
      for (int n = 0; n < 400; n++) begin
         bit rst;
         rst = ($urandom_range(0, 59) == 0);
         drive(rst, bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 32'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), 32'($urandom_range(0, 8)));
      end

      cur_tag = "drain";
      idle();
      idle();
      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
